cmd_parser: RTL and testbench
=============================

CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter: DATA_BIT, 32, pattern width in bits; SHALL be a multiple of 8 (PB = DATA_BIT/8 bytes per pattern).
REQ-002 Parameter: HEADER, 8'hA5, frame start byte.
REQ-003 Parameter: TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between bytes inside a frame.
REQ-004 Port: clk  in  1  the single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: i_rx_data  in  8  received byte from the UART receiver.
REQ-007 Port: i_rx_done_tick  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-008 Port: o_output_pattern  out  DATA_BIT  committed output pattern for the serializer.
REQ-009 Port: o_freq_pattern  out  DATA_BIT  committed per-bit speed select (1 = fast).
REQ-010 Port: o_slow_period, o_fast_period  out  8 each  committed bit periods in clk cycles.
REQ-011 Port: o_mode  out  1  committed mode, 0 one-shot, 1 repeat.
REQ-012 Port: o_start, o_stop  out  1 each  one-cycle command pulses to the serializer.
REQ-013 Port: o_err_tick  out  1  one-cycle pulse on any rejected frame.
REQ-014 Port: o_busy  out  1  high while a frame is partially received (state not S_HDR).

Function
REQ-015 Frame SHALL be: HEADER, CMD, payload, CHK; CHK = XOR of CMD and all payload bytes.
REQ-016 CMD 8'h01 LOAD payload SHALL be 2*PB+3 bytes: output pattern LSB-byte first, freq pattern LSB-byte first, slow period, fast period, mode byte (bit0 used, bits 7:1 ignored).
REQ-017 CMD 8'h02 START and 8'h03 STOP SHALL carry zero payload bytes.
REQ-018 States SHALL be S_HDR, S_CMD, S_PAYLOAD, S_CHK; bytes are consumed only in cycles with i_rx_done_tick high.
REQ-019 S_HDR: byte == HEADER -> S_CMD; any other byte is discarded silently.
REQ-020 S_CMD: 01 -> S_PAYLOAD with byte count cleared; 02/03 -> S_CHK; any other value -> o_err_tick, S_HDR.
REQ-021 S_PAYLOAD: bytes SHALL go to shadow registers only, never to outputs; after the last payload byte -> S_CHK.
REQ-022 S_CHK: mismatch -> o_err_tick, S_HDR, outputs unchanged; match -> execute, S_HDR.
REQ-023 LOAD execute: if either shadow period is 0, pulse o_err_tick and commit nothing; otherwise commit all five fields simultaneously.
REQ-024 Execute latency: committed outputs, o_start or o_stop SHALL change in the cycle after the CHK byte's strobe, all registered.
REQ-025 LOAD SHALL NOT pulse o_start; the serializer restarts only on a START frame.
REQ-026 Timeout: when not in S_HDR, the inter-byte counter SHALL clear on every strobe; reaching TIMEOUT_CYCLES-1 with no strobe -> o_err_tick, S_HDR.
REQ-027 Strobe in the same cycle as timeout expiry: the byte SHALL win; no error is raised.
REQ-028 A HEADER value arriving mid-frame SHALL be treated as data, not as a resync.
REQ-029 o_start, o_stop and o_err_tick SHALL be mutually exclusive and last exactly one cycle.

Reset
REQ-030 rst SHALL force S_HDR and clear shadows, counters, all pulses and o_busy.
REQ-031 On rst, o_output_pattern = 0, o_freq_pattern = 0, o_mode = 0, o_slow_period = 9, o_fast_period = 3.
REQ-032 rst asserted mid-frame SHALL discard the partial frame without an error pulse.

Structure
REQ-033 Package serial_cmd_pkg SHALL hold HEADER, the command codes, the state encodings and the default periods 9/3.
REQ-034 Inter-byte timeout counter SHALL be the sub-module frame_timer (inputs: clear and enable; output: expired).

Verification
REQ-035 Reset, then LOAD: A5 01 EF BE AD DE F0 00 00 00 0A 02 01 CHK -> one cycle after CHK: o_output_pattern = 32'hDEADBEEF, o_freq_pattern = 32'h000000F0, periods 10/2, o_mode = 1, no o_start.
REQ-036 A5 02 02 -> o_start high for exactly one cycle; A5 03 03 -> o_stop high for exactly one cycle.
REQ-037 The REQ-035 LOAD with CHK off by one bit -> one o_err_tick; outputs hold their reset values.
REQ-038 LOAD with slow period byte 00 and correct CHK -> o_err_tick; nothing committed.
REQ-039 A5 01 then idle TIMEOUT_CYCLES cycles -> o_err_tick, o_busy low; a following A5 02 02 -> o_start. Also: strobe exactly at expiry -> no error.
REQ-040 Assert rst after 5 LOAD payload bytes -> no o_err_tick; outputs return to reset values; a subsequent full LOAD succeeds.

Source files
------------

// File: rtl/serial_cmd_pkg.sv
// Shared constants for the UART command parser: frame header, command
// codes, parser state encodings and the power-up bit periods.
package serial_cmd_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;
    localparam logic [7:0] CMD_STOP  = 8'h03;

    localparam logic [7:0] DEF_SLOW_PERIOD = 8'd9;
    localparam logic [7:0] DEF_FAST_PERIOD = 8'd3;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_CMD     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHK     = 2'd3
    } state_t;

    // LOAD payload: two patterns, slow period, fast period, mode byte
    function automatic int load_payload_len(input int data_bit);
        return 2 * (data_bit / 8) + 3;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags when the
// count reaches TIMEOUT_CYCLES-1. Clear has priority over counting.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear on request, otherwise count up and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/cmd_parser.sv
// Byte-stream command parser for the pattern serializer. Frames are
// HEADER, CMD, payload, CHK (XOR of CMD and payload). LOAD payloads are
// staged in shadow registers and committed atomically only after a good
// checksum and non-zero periods; START/STOP produce one-cycle pulses.
module cmd_parser
    import serial_cmd_pkg::*;
#(
    parameter int         DATA_BIT       = 32,
    parameter logic [7:0] HEADER         = HEADER_BYTE,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done_tick,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [7:0]          o_slow_period,
    output logic [7:0]          o_fast_period,
    output logic                o_mode,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_err_tick,
    output logic                o_busy
);

    localparam int PB    = DATA_BIT / 8;
    localparam int PLEN  = load_payload_len(DATA_BIT);
    localparam int CNT_W = $clog2(PLEN + 1);

    localparam logic [CNT_W-1:0] IDX_FREQ = CNT_W'(PB);
    localparam logic [CNT_W-1:0] IDX_SLOW = CNT_W'(2 * PB);
    localparam logic [CNT_W-1:0] IDX_FAST = CNT_W'(2 * PB + 1);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(PLEN - 1);

    state_t              state_q;
    logic [7:0]          cmd_q;
    logic [7:0]          chk_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_BIT-1:0] sh_out_q;
    logic [DATA_BIT-1:0] sh_freq_q;
    logic [7:0]          sh_slow_q;
    logic [7:0]          sh_fast_q;
    logic                sh_mode_q;

    logic [DATA_BIT-1:0] out_pat_q;
    logic [DATA_BIT-1:0] freq_q;
    logic [7:0]          slow_q;
    logic [7:0]          fast_q;
    logic                mode_q;
    logic                start_q;
    logic                stop_q;
    logic                err_q;

    logic                tmr_clear;
    logic                tmr_enable;
    logic                tmr_expired;

    // The watchdog runs only inside a frame and restarts on every byte
    assign tmr_enable = (state_q != S_HDR);
    assign tmr_clear  = i_rx_done_tick || (state_q == S_HDR);

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    // Frame FSM: consumes strobed bytes, stages LOAD data, commits/pulses on CHK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HDR;
            cmd_q     <= '0;
            chk_q     <= '0;
            cnt_q     <= '0;
            sh_out_q  <= '0;
            sh_freq_q <= '0;
            sh_slow_q <= '0;
            sh_fast_q <= '0;
            sh_mode_q <= 1'b0;
            out_pat_q <= '0;
            freq_q    <= '0;
            slow_q    <= DEF_SLOW_PERIOD;
            fast_q    <= DEF_FAST_PERIOD;
            mode_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;

            // A byte in the expiry cycle takes precedence over the timeout
            if (i_rx_done_tick) begin
                case (state_q)
                    S_HDR: begin
                        if (i_rx_data == HEADER) begin
                            state_q <= S_CMD;
                        end
                    end

                    S_CMD: begin
                        cmd_q <= i_rx_data;
                        chk_q <= i_rx_data;
                        cnt_q <= '0;
                        case (i_rx_data)
                            CMD_LOAD:            state_q <= S_PAYLOAD;
                            CMD_START, CMD_STOP: state_q <= S_CHK;
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_HDR;
                            end
                        endcase
                    end

                    S_PAYLOAD: begin
                        // Header-valued bytes are ordinary data here
                        chk_q <= chk_q ^ i_rx_data;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q < IDX_FREQ) begin
                            sh_out_q <= DATA_BIT'({i_rx_data, sh_out_q} >> 8);
                        end else if (cnt_q < IDX_SLOW) begin
                            sh_freq_q <= DATA_BIT'({i_rx_data, sh_freq_q} >> 8);
                        end else if (cnt_q == IDX_SLOW) begin
                            sh_slow_q <= i_rx_data;
                        end else if (cnt_q == IDX_FAST) begin
                            sh_fast_q <= i_rx_data;
                        end else begin
                            sh_mode_q <= i_rx_data[0];
                        end
                        if (cnt_q == IDX_LAST) begin
                            state_q <= S_CHK;
                        end
                    end

                    S_CHK: begin
                        state_q <= S_HDR;
                        if (i_rx_data != chk_q) begin
                            err_q <= 1'b1;
                        end else begin
                            case (cmd_q)
                                CMD_LOAD: begin
                                    if ((sh_slow_q == 8'd0) || (sh_fast_q == 8'd0)) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        out_pat_q <= sh_out_q;
                                        freq_q    <= sh_freq_q;
                                        slow_q    <= sh_slow_q;
                                        fast_q    <= sh_fast_q;
                                        mode_q    <= sh_mode_q;
                                    end
                                end
                                CMD_START: start_q <= 1'b1;
                                CMD_STOP:  stop_q  <= 1'b1;
                                default:   err_q   <= 1'b1;
                            endcase
                        end
                    end

                    default: state_q <= S_HDR;
                endcase
            end else if (tmr_expired) begin
                err_q   <= 1'b1;
                state_q <= S_HDR;
            end
        end
    end

    assign o_output_pattern = out_pat_q;
    assign o_freq_pattern   = freq_q;
    assign o_slow_period    = slow_q;
    assign o_fast_period    = fast_q;
    assign o_mode           = mode_q;
    assign o_start          = start_q;
    assign o_stop           = stop_q;
    assign o_err_tick       = err_q;
    assign o_busy           = (state_q != S_HDR);

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: a table of complete frames with their
// expected pulses and committed fields, then timeout and reset sequences.
module tb_cmd_parser;

    localparam int TO = 40;

    logic        clk;
    logic        rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_done_tick;
    logic [31:0] o_output_pattern;
    logic [31:0] o_freq_pattern;
    logic [7:0]  o_slow_period;
    logic [7:0]  o_fast_period;
    logic        o_mode;
    logic        o_start;
    logic        o_stop;
    logic        o_err_tick;
    logic        o_busy;

    cmd_parser #(
        .DATA_BIT       (32),
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rx_data        (i_rx_data),
        .i_rx_done_tick   (i_rx_done_tick),
        .o_output_pattern (o_output_pattern),
        .o_freq_pattern   (o_freq_pattern),
        .o_slow_period    (o_slow_period),
        .o_fast_period    (o_fast_period),
        .o_mode           (o_mode),
        .o_start          (o_start),
        .o_stop           (o_stop),
        .o_err_tick       (o_err_tick),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_multi = 0;

    // Pulse counters sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (o_err_tick) n_err++;
        if (o_start)    n_start++;
        if (o_stop)     n_stop++;
        if ((int'(o_err_tick) + int'(o_start) + int'(o_stop)) > 1) n_multi++;
    end

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           cm;      // 0: no CHK appended, 1: good CHK, 2: CHK with bit0 flipped
        logic         e_err;
        logic         e_start;
        logic         e_stop;
        logic [31:0]  e_out;
        logic [31:0]  e_freq;
        logic [7:0]   e_slow;
        logic [7:0]   e_fast;
        logic         e_mode;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mkv(logic [127:0] b, int len, int cm, logic e, logic s, logic p,
                                 logic [31:0] o, logic [31:0] f, logic [7:0] sl,
                                 logic [7:0] fa, logic m);
        vec_t v;
        v.bytes = b; v.len = len; v.cm = cm;
        v.e_err = e; v.e_start = s; v.e_stop = p;
        v.e_out = o; v.e_freq = f; v.e_slow = sl; v.e_fast = fa; v.e_mode = m;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; the byte is sampled on the next rising edge
    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        @(negedge clk);
        i_rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input vec_t v);
        logic [127:0] sh;
        logic [7:0]   c;
        c = 8'h00;
        for (int k = 0; k < v.len; k++) begin
            sh = v.bytes >> (8 * (v.len - 1 - k));
            send_byte(sh[7:0]);
            if (k >= 1) c = c ^ sh[7:0];
        end
        if (v.cm == 1) send_byte(c);
        if (v.cm == 2) send_byte(c ^ 8'h01);
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] o, input logic [31:0] f,
                                 input logic [7:0] sl, input logic [7:0] fa, input logic m);
        check({tag, "_out"},  o_output_pattern, o);
        check({tag, "_freq"}, o_freq_pattern,   f);
        check({tag, "_slow"}, 32'(o_slow_period), 32'(sl));
        check({tag, "_fast"}, 32'(o_fast_period), 32'(fa));
        check({tag, "_mode"}, 32'(o_mode), 32'(m));
    endtask

    initial begin
        int e0, s0, p0;
        string tag;

        rst = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done_tick = 1'b0;

        vt[0] = mkv(128'({8'hA5,8'h01,8'hEF,8'hBE,8'hAD,8'hDE,8'hF0,8'h00,8'h00,8'h00,8'h0A,8'h02,8'h01}),
                    13, 2, 1, 0, 0, 32'h0, 32'h0, 8'd9, 8'd3, 0);
        vt[1] = mkv(128'({8'hA5,8'h01,8'hEF,8'hBE,8'hAD,8'hDE,8'hF0,8'h00,8'h00,8'h00,8'h0A,8'h02,8'h01}),
                    13, 1, 0, 0, 0, 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[2] = mkv(128'({8'hA5,8'h02}), 2, 1, 0, 1, 0, 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[3] = mkv(128'({8'hA5,8'h03}), 2, 1, 0, 0, 1, 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[4] = mkv(128'({8'hA5,8'h01,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h00,8'h05,8'h00}),
                    13, 1, 1, 0, 0, 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[5] = mkv(128'({8'hA5,8'h07}), 2, 0, 1, 0, 0, 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[6] = mkv(128'({8'h00,8'h5A,8'hA5,8'h03,8'h03}), 5, 0, 0, 0, 1,
                    32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        vt[7] = mkv(128'({8'hA5,8'h01,8'hA5,8'hA5,8'h00,8'h11,8'hFF,8'h00,8'hFF,8'h00,8'h04,8'h07,8'hFE}),
                    13, 1, 0, 0, 0, 32'h1100A5A5, 32'h00FF00FF, 8'd4, 8'd7, 0);
        vt[8] = mkv(128'({8'hA5,8'h01,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h00,8'h01}),
                    13, 1, 1, 0, 0, 32'h1100A5A5, 32'h00FF00FF, 8'd4, 8'd7, 0);
        vt[9] = mkv(128'({8'hA5,8'h02}), 2, 2, 1, 0, 0, 32'h1100A5A5, 32'h00FF00FF, 8'd4, 8'd7, 0);

        // Reset values
        idle(3);
        check_outputs("reset", 32'h0, 32'h0, 8'd9, 8'd3, 0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_pulses", 32'({o_start, o_stop, o_err_tick}), 32'd0);
        rst = 1'b0;
        idle(2);

        // Table of complete frames
        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("v%0d", i);
            e0 = n_err; s0 = n_start; p0 = n_stop;
            send_frame(vt[i]);
            // Registered results are visible in the cycle after the final byte
            check({tag, "_err_now"},   32'(o_err_tick), 32'(vt[i].e_err));
            check({tag, "_start_now"}, 32'(o_start),    32'(vt[i].e_start));
            check({tag, "_stop_now"},  32'(o_stop),     32'(vt[i].e_stop));
            check_outputs(tag, vt[i].e_out, vt[i].e_freq, vt[i].e_slow, vt[i].e_fast, vt[i].e_mode);
            idle(2);
            check({tag, "_err_cycles"},   32'(n_err - e0),   32'(vt[i].e_err));
            check({tag, "_start_cycles"}, 32'(n_start - s0), 32'(vt[i].e_start));
            check({tag, "_stop_cycles"},  32'(n_stop - p0),  32'(vt[i].e_stop));
            check({tag, "_busy"}, 32'(o_busy), 32'd0);
        end

        // Timeout after A5 01, then recovery with START
        e0 = n_err; s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h01);
        check("to_busy", 32'(o_busy), 32'd1);
        idle(TO - 1);
        check("to_early_err", 32'(n_err - e0), 32'd0);
        idle(1);
        check("to_err", 32'(n_err - e0), 32'd1);
        check("to_busy_after", 32'(o_busy), 32'd0);
        idle(2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        idle(2);
        check("to_recover_start", 32'(n_start - s0), 32'd1);
        check("to_err_once", 32'(n_err - e0), 32'd1);

        // Byte arriving in the exact expiry cycle wins
        e0 = n_err; s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h02);
        idle(TO - 1);
        send_byte(8'h02);
        idle(2);
        check("edge_no_err", 32'(n_err - e0), 32'd0);
        check("edge_start", 32'(n_start - s0), 32'd1);

        // Reset in the middle of a LOAD payload
        e0 = n_err;
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        check("mid_busy", 32'(o_busy), 32'd1);
        check("mid_out_held", o_output_pattern, 32'h1100A5A5);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("mid_rst", 32'h0, 32'h0, 8'd9, 8'd3, 0);
        rst = 1'b0;
        idle(2);
        check("mid_rst_no_err", 32'(n_err - e0), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        send_frame(vt[1]);
        check_outputs("post_rst_load", 32'hDEADBEEF, 32'h000000F0, 8'd10, 8'd2, 1);
        idle(2);
        check("post_rst_err", 32'(n_err - e0), 32'd0);

        check("pulse_exclusive", 32'(n_multi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
